// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM state encoding and the
// per-micro-operation control vector layout driven by div_cu.
package div_pkg;
  localparam int W_DEF = 8;

  typedef enum logic [3:0] {
    IDLE, LOAD_M, LOAD_Q, SHIFT, SUB, FIX, CHECK, OUTPUT_A, OUTPUT_Q, STOP
  } state_t;

  localparam int CV_LOAD_M = 0;
  localparam int CV_LOAD_Q = 1;
  localparam int CV_SHIFT  = 2;
  localparam int CV_SUB    = 3;
  localparam int CV_FIX    = 4;
  localparam int CV_OUT_A  = 5;
  localparam int CV_OUT_Q  = 6;
  localparam int CV_N      = 7;

  typedef logic [CV_N-1:0] ctl_t;
endpackage

// File: rtl/restoring_div_if.sv
// Host-side bus of the divider: shared operand input, shared result output,
// and status strobes. master = host controller, slave = divider.
interface restoring_div_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         busy;
  logic         stop;
  logic         dz;

  modport master (output start, inbus, input outbus, busy, stop, dz);
  modport slave  (input start, inbus, output outbus, busy, stop, dz);
endinterface

// File: rtl/div_cu.sv
// Divider controller: next-state and one-hot micro-op decode from the current
// state and datapath status. The state register lives in the datapath top.
module div_cu
  import div_pkg::*;
(
  input  state_t state,
  input  logic   start,
  input  logic   a_sign,
  input  logic   cnt_zero,
  input  logic   m_zero,
  output state_t state_nxt,
  output ctl_t   ctl,
  output logic   restore,
  output logic   stop,
  output logic   busy
);
  always_comb begin
    state_nxt = state;
    ctl       = '0;
    restore   = 1'b0;
    stop      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:     if (start) state_nxt = LOAD_M;
      LOAD_M:   begin ctl[CV_LOAD_M] = 1'b1; state_nxt = LOAD_Q; end
      LOAD_Q:   begin
        ctl[CV_LOAD_Q] = 1'b1;
        state_nxt = m_zero ? OUTPUT_A : SHIFT;
      end
      SHIFT:    begin ctl[CV_SHIFT] = 1'b1; state_nxt = SUB; end
      SUB:      begin ctl[CV_SUB] = 1'b1; state_nxt = FIX; end
      // Negative partial remainder after SUB means M did not fit: add it back.
      FIX:      begin ctl[CV_FIX] = 1'b1; restore = a_sign; state_nxt = CHECK; end
      CHECK:    state_nxt = cnt_zero ? OUTPUT_A : SHIFT;
      OUTPUT_A: begin ctl[CV_OUT_A] = 1'b1; state_nxt = OUTPUT_Q; end
      OUTPUT_Q: begin ctl[CV_OUT_Q] = 1'b1; state_nxt = STOP; end
      STOP:     begin stop = 1'b1; state_nxt = IDLE; end
      default:  state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/restoring_div.sv
// Sequential unsigned restoring divider datapath (A/M/Q/cnt, add/sub, output
// mux) with the state register; sequencing decoded by div_cu.
module restoring_div
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  restoring_div_if.slave   bus
);
  localparam int CW = $clog2(W+1);

  state_t        state_q, state_d;
  logic [W:0]    a_q, a_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  ctl_t ctl;
  logic restore, stop, busy;

  div_cu u_cu (
    .state     (state_q),
    .start     (bus.start),
    .a_sign    (a_q[W]),
    .cnt_zero  (cnt_q == '0),
    .m_zero    (m_q == '0),
    .state_nxt (state_d),
    .ctl       (ctl),
    .restore   (restore),
    .stop      (stop),
    .busy      (busy)
  );

  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (ctl[CV_LOAD_M]) m_d = bus.inbus;
    if (ctl[CV_LOAD_Q]) begin
      q_d   = bus.inbus;
      a_d   = '0;
      cnt_d = CW'(W);
      dz_d  = (m_q == '0);
    end
    // {A,Q} shifted as one register; A's sign bit falls off the top.
    if (ctl[CV_SHIFT]) begin
      a_d = {a_q[W-1:0], q_q[W-1]};
      q_d = {q_q[W-2:0], 1'b0};
    end
    if (ctl[CV_SUB]) a_d = a_q - {1'b0, m_q};
    if (ctl[CV_FIX]) begin
      if (restore) a_d = a_q + {1'b0, m_q};
      q_d[0] = ~restore;
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  // Zero divisor reports remainder = dividend, quotient = all ones.
  always_comb begin
    bus.outbus = '0;
    if (ctl[CV_OUT_A])      bus.outbus = dz_q ? q_q : a_q[W-1:0];
    else if (ctl[CV_OUT_Q]) bus.outbus = dz_q ? '1 : q_q;
  end

  assign bus.busy = busy;
  assign bus.stop = stop;
  assign bus.dz   = dz_q & (ctl[CV_OUT_A] | ctl[CV_OUT_Q] | stop);
endmodule

// File: doc/restoring_div.md
# restoring_div

Sequential unsigned restoring divider: the inverse companion to the Booth multiplier, sharing its load-M / load-Q / iterate / output-A / output-Q / stop bus protocol. Divisor and dividend arrive one per cycle on a shared input bus. W shift/subtract/restore iterations follow. Remainder, then quotient, leave on a shared output bus, and a one-cycle stop pulse marks completion. It sits beside the multiplier in the arithmetic unit and is sequenced by the same host controller.

## Interface
- W, 8, operand width (dividend, divisor, quotient, remainder)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- inbus  in  W  operand input; divisor during LOAD_M, dividend during LOAD_Q
- outbus  out  W  remainder during OUTPUT_A, quotient during OUTPUT_Q, 0 otherwise
- busy  out  1  high whenever state != IDLE
- stop  out  1  one-cycle completion pulse (STOP state)
- dz  out  1  divide-by-zero flag; high during OUTPUT_A, OUTPUT_Q and STOP of a zero-divisor operation

## Operation
- Registers:
  - M: W bits, divisor.
  - A: W+1 bits, signed partial remainder.
  - Q: W bits, dividend/quotient.
  - cnt: clog2(W+1) bits.
  - dz_r: 1 bit.
- States: IDLE, LOAD_M, LOAD_Q, SHIFT, SUB, FIX, CHECK, OUTPUT_A, OUTPUT_Q, STOP.
- IDLE: if start, go to LOAD_M; else stay.
- LOAD_M: M <= inbus; go to LOAD_Q.
- LOAD_Q:
  - Q <= inbus; A <= 0; cnt <= W.
  - If M == 0: dz_r <= 1, go to OUTPUT_A.
  - Else: dz_r <= 0, go to SHIFT.
- SHIFT: {A,Q} <= {A,Q} << 1 (Q[0] <= 0); go to SUB.
- SUB: A <= A - {1'b0,M}, computed at W+1 bits; go to FIX.
- FIX:
  - If A[W] == 1: A <= A + {1'b0,M} (restore), Q[0] <= 0.
  - Else: Q[0] <= 1.
  - cnt <= cnt - 1. Go to CHECK.
- CHECK: if cnt == 0, go to OUTPUT_A; else go to SHIFT.
- OUTPUT_A: outbus = dz_r ? Q : A[W-1:0]; go to OUTPUT_Q.
- OUTPUT_Q: outbus = dz_r ? all-ones : Q; go to STOP.
- STOP: stop = 1; go to IDLE unconditionally.
- Result invariants:
  - On exit from the loop, A[W] == 0 and A < M.
  - Dividend = Q*M + A.
- Divide-by-zero result: remainder = dividend, quotient = 2^W-1.
- start outside IDLE is ignored; inbus outside LOAD_M/LOAD_Q is ignored.

## Timing
- Reset values:
  - state IDLE; M, A, Q, cnt, dz_r all 0.
  - Outputs: outbus 0, busy 0, stop 0, dz 0.
- Cycle 0 is an IDLE cycle with start=1.
  - LOAD_M at cycle 1, LOAD_Q at cycle 2.
  - Iterations occupy cycles 3 .. 3+4W-1.
  - OUTPUT_A at 3+4W, OUTPUT_Q at 4+4W, STOP at 5+4W. For W=8: 35, 36, 37.
- Zero divisor: OUTPUT_A at cycle 3, OUTPUT_Q at 4, STOP at 5.
- All outputs are decoded combinationally from state and registers. outbus is valid for exactly one cycle per field.
- The cycle after STOP is always IDLE, so back-to-back operations have at least one IDLE cycle between them. start held high restarts at STOP+2.
- rst_n asserted mid-operation: immediate return to IDLE, registers cleared, no stop pulse. The operation is lost.

## Structure
- Package div_pkg holds:
  - state_t enum (logic [3:0]).
  - The default width constant.
  - A control-vector bit index per micro-operation (load_m, load_q, shift, sub, fix, out_a, out_q).
- Split into controller sub-module div_cu and datapath.
  - div_cu inputs: state, start, a_sign (A[W]), cnt_zero, m_zero.
  - div_cu outputs: one-hot control vector, stop, busy.
  - The datapath (A/M/Q/cnt, adder/subtractor, output mux) lives in restoring_div.

## Test plan
- 100 / 7, W=8 -> outbus 0x02 at cycle 35, 0x0E at cycle 36; stop=1 at cycle 37 only; dz=0; busy=1 for cycles 1-37.
- 255 / 1 -> remainder 0x00, quotient 0xFF; 5 / 9 -> remainder 0x05, quotient 0x00; 0 / 3 -> 0x00, 0x00.
- 200 / 0 -> dz=1 cycles 3-5; outbus 0xC8 at cycle 3, 0xFF at cycle 4; stop at cycle 5.
- start held high through two operations (100/7 then 255/16) -> second LOAD_M at cycle 39; results 0x02/0x0E then 0x0F/0x0F; start pulses during busy ignored.
- rst_n low at cycle 20 of a 100/7 operation -> all outputs 0 within the same cycle, no stop. New 9/3 after release -> 0x00, 0x03 with normal timing.
- Random sweep of all 65536 operand pairs at W=8 against a reference divider. Check quotient/remainder and dz, plus stop exactly once per operation.
